// File: rtl/dn_write_arbiter.sv
// Download write arbiter: buffers ioctl byte writes in a small FIFO and drains
// them into a shared memory port, yielding to the CPU with a starvation limit.
module dn_write_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  output logic              cpu_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic [7:0]        mem_index,
  output logic              dn_busy,
  output logic              dn_done,
  output logic              dn_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [7:0]        index;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [SC_W-1:0]   starve_cnt;
  logic              empty, full, dl_slot, wr_req, push, drop;

  if (ADDR_W < 25) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^ioctl_addr[24:ADDR_W];
  end

  always_comb begin
    empty     = (count == '0);
    full      = (count == CNT_W'(FIFO_DEPTH));
    dl_slot   = !empty && (!cpu_req || starve_cnt == SC_W'(STARVE_LIMIT));
    cpu_grant = cpu_req && !dl_slot;
    wr_req    = ioctl_wr && ioctl_download;
    // a same-cycle pop frees the slot, so a full buffer can still accept
    push      = wr_req && (!full || dl_slot);
    drop      = wr_req && full && !dl_slot;
    count_nxt = count;
    if (push && !dl_slot)      count_nxt = count + CNT_W'(1);
    else if (!push && dl_slot) count_nxt = count - CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ioctl_download) state_nxt = LOAD;
      LOAD:  if (!ioctl_download) state_nxt = FLUSH;
      FLUSH: if (ioctl_download) state_nxt = LOAD;
             else if (empty && !mem_we) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dn_busy = (state == LOAD) || (state == FLUSH);
  assign dn_done = (state == DONE);

  // storage is not reset; emptying the pointers discards the contents
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout, index: ioctl_index};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      ioctl_wait  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_index   <= '0;
      dn_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      ioctl_wait <= (count_nxt >= CNT_W'(FIFO_DEPTH - 1));
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (dl_slot) rd_ptr <= rd_ptr + PTR_W'(1);
      mem_we <= dl_slot;
      if (dl_slot) begin
        mem_addr  <= fifo_mem[rd_ptr].addr;
        mem_data  <= fifo_mem[rd_ptr].data;
        mem_index <= fifo_mem[rd_ptr].index;
      end
      if (dl_slot || empty)
        starve_cnt <= '0;
      else if (cpu_grant && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SC_W'(1);
      if (drop)
        dn_overflow <= 1'b1;
      else if (state == IDLE && ioctl_download)
        dn_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dn_write_arbiter.sv
// Directed bench for dn_write_arbiter: vector table for a plain download plus
// hand-written sequences for starvation, overflow, full-boundary, reset, refill.
module tb_dn_write_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, cpu_req;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait, cpu_grant, mem_we, dn_busy, dn_done, dn_overflow;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data, mem_index;

  int n_cmp = 0;
  int n_bad = 0;

  dn_write_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .cpu_req(cpu_req),
    .cpu_grant(cpu_grant), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_index(mem_index), .dn_busy(dn_busy),
    .dn_done(dn_done), .dn_overflow(dn_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        dl, wr, cpu;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [16:0] maddr;
    logic [7:0]  mdata;
    logic        grant, wt, busy, done, ovf;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; cpu_req = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 8'h5A;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    cyc();
    ioctl_wr = 1'b0;
  endtask

  initial begin
    int n, dcnt;
    logic found;

    //        dl wr cpu addr dout | we maddr mdata gr wt busy done ovf
    tv[0]  = '{0, 0, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 0, 8'hA1,  0, 0, 8'h00, 0, 0, 1, 0, 0};
    tv[3]  = '{1, 1, 0, 1, 8'hA2,  0, 0, 8'h00, 0, 0, 1, 0, 0};
    tv[4]  = '{1, 1, 0, 2, 8'hA3,  1, 0, 8'hA1, 0, 0, 1, 0, 0};
    tv[5]  = '{1, 0, 0, 0, 8'h00,  1, 1, 8'hA2, 0, 0, 1, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 8'h00,  1, 2, 8'hA3, 0, 0, 1, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 8'h00,  0, 2, 8'hA3, 0, 0, 1, 0, 0};
    tv[8]  = '{0, 0, 0, 0, 8'h00,  0, 2, 8'hA3, 0, 0, 0, 1, 0};
    tv[9]  = '{0, 0, 0, 0, 8'h00,  0, 2, 8'hA3, 0, 0, 0, 0, 0};
    tv[10] = '{0, 1, 0, 9, 8'h77,  0, 2, 8'hA3, 0, 0, 0, 0, 0};
    tv[11] = '{0, 0, 0, 0, 8'h00,  0, 2, 8'hA3, 0, 0, 0, 0, 0};
    tv[12] = '{0, 0, 0, 0, 8'h00,  0, 2, 8'hA3, 0, 0, 0, 0, 0};

    // plain download with the CPU idle, then a write outside a session
    do_reset();
    for (int i = 0; i < 13; i++) begin
      ioctl_download = tv[i].dl; ioctl_wr = tv[i].wr; cpu_req = tv[i].cpu;
      ioctl_addr = tv[i].addr; ioctl_dout = tv[i].dout;
      #1;
      chk($sformatf("a%0d_we", i),    mem_we,      tv[i].we);
      chk($sformatf("a%0d_addr", i),  mem_addr,    tv[i].maddr);
      chk($sformatf("a%0d_data", i),  mem_data,    tv[i].mdata);
      chk($sformatf("a%0d_grant", i), cpu_grant,   tv[i].grant);
      chk($sformatf("a%0d_wait", i),  ioctl_wait,  tv[i].wt);
      chk($sformatf("a%0d_busy", i),  dn_busy,     tv[i].busy);
      chk($sformatf("a%0d_done", i),  dn_done,     tv[i].done);
      chk($sformatf("a%0d_ovf", i),   dn_overflow, tv[i].ovf);
      cyc();
    end

    // starvation limit: write accepted in the IDLE cycle, CPU holds the port
    do_reset();
    cpu_req = 1'b1; ioctl_download = 1'b1; ioctl_index = 8'h03;
    push(25'h10, 8'h55);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_grant%0d", i), cpu_grant, 1);
      chk($sformatf("b_we%0d", i), mem_we, 0);
      cyc();
    end
    chk("b_grant_yield", cpu_grant, 0);
    cyc();
    chk("b_we", mem_we, 1);
    chk("b_addr", mem_addr, 32'h10);
    chk("b_data", mem_data, 8'h55);
    chk("b_index", mem_index, 8'h03);
    chk("b_grant_back", cpu_grant, 1);

    // overflow: five back-to-back writes into a 4-deep buffer
    do_reset();
    cpu_req = 1'b1; ioctl_download = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      push(25'(k), 8'hB0 + 8'(k));
      chk($sformatf("c_wait%0d", k), ioctl_wait, (k >= 2) ? 1 : 0);
      chk($sformatf("c_ovf%0d", k), dn_overflow, (k == 4) ? 1 : 0);
    end
    ioctl_download = 1'b0; cpu_req = 1'b0;
    n = 0; dcnt = 0;
    repeat (12) begin
      cyc();
      if (mem_we) begin
        chk($sformatf("c_drain%0d", n), mem_data, 8'hB0 + 8'(n));
        n++;
      end
      if (dn_done) dcnt++;
    end
    chk("c_drain_cnt", n, 4);
    chk("c_done_cnt", dcnt, 1);
    chk("c_ovf_sticky", dn_overflow, 1);
    ioctl_download = 1'b1;
    cyc();
    chk("c_ovf_clear", dn_overflow, 0);

    // full buffer with a pop in the same cycle as a write
    do_reset();
    cpu_req = 1'b1; ioctl_download = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) push(25'(k), 8'hC0 + 8'(k));
    found = 1'b0;
    for (int t = 0; t < 12 && !found; t++) begin
      if (!cpu_grant) begin
        found = 1'b1;
        chk("d_full_wait", ioctl_wait, 1);
        push(25'h4, 8'hC4);
      end else begin
        cyc();
      end
    end
    chk("d_slot_found", found, 1);
    chk("d_ovf", dn_overflow, 0);
    chk("d_we", mem_we, 1);
    chk("d_data0", mem_data, 8'hC0);
    chk("d_wait_full", ioctl_wait, 1);
    ioctl_download = 1'b0; cpu_req = 1'b0;
    n = 1;
    repeat (10) begin
      cyc();
      if (mem_we) begin
        chk($sformatf("d_drain%0d", n), mem_data, 8'hC0 + 8'(n));
        n++;
      end
    end
    chk("d_drain_cnt", n, 5);

    // reset mid-download with two entries still buffered
    do_reset();
    cpu_req = 1'b1; ioctl_download = 1'b1; ioctl_index = 8'h01;
    cyc();
    for (int k = 0; k < 3; k++) push(25'h5 + 25'(k), 8'hD5 + 8'(k));
    cpu_req = 1'b0;
    cyc();
    cpu_req = 1'b1;
    #1;
    chk("e_pre_we", mem_we, 1);
    chk("e_pre_addr", mem_addr, 32'h5);
    chk("e_pre_busy", dn_busy, 1);
    #1;
    reset = 1'b1; ioctl_download = 1'b0;
    #1;
    chk("e_rst_we", mem_we, 0);
    chk("e_rst_addr", mem_addr, 0);
    chk("e_rst_data", mem_data, 0);
    chk("e_rst_index", mem_index, 0);
    chk("e_rst_wait", ioctl_wait, 0);
    chk("e_rst_busy", dn_busy, 0);
    chk("e_rst_done", dn_done, 0);
    chk("e_rst_ovf", dn_overflow, 0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0; cpu_req = 1'b1;
    #1;
    chk("e_grant_follow", cpu_grant, 1);
    cpu_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("e_no_we%0d", i), mem_we, 0);
      chk($sformatf("e_idle%0d", i), dn_busy, 0);
    end

    // download drops and returns while entries are pending
    do_reset();
    cpu_req = 1'b1; ioctl_download = 1'b1;
    cyc();
    push(25'h20, 8'hE0);
    push(25'h21, 8'hE1);
    ioctl_download = 1'b0;
    cyc();
    chk("f_flush_busy", dn_busy, 1);
    chk("f_flush_done", dn_done, 0);
    ioctl_download = 1'b1;
    cyc();
    chk("f_reload_busy", dn_busy, 1);
    cpu_req = 1'b0;
    n = 0; dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (mem_we) begin
        chk($sformatf("f_data%0d", n), mem_data, 8'hE0 + 8'(n));
        n++;
      end
      if (dn_done) dcnt++;
      chk($sformatf("f_busy%0d", i), dn_busy, 1);
    end
    chk("f_written", n, 2);
    chk("f_no_done", dcnt, 0);
    ioctl_download = 1'b0;
    repeat (6) begin
      cyc();
      if (dn_done) dcnt++;
    end
    chk("f_final_done", dcnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
